// File: rtl/sata_phy_pkg.sv
// Shared definitions for the SATA PHY control slice: DRP bus widths, the
// DRP arbiter FSM state encoding and the read data returned on a timeout.
// No ports; imported by drp_port_capture and drp_arbiter.
package sata_phy_pkg;

   localparam int DRP_ADDR_W = 7;
   localparam int DRP_DATA_W = 16;

   // Read data handed back to a requester when the GTP never answers
   localparam logic [DRP_DATA_W-1:0] DRP_TIMEOUT_FILL = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESPOND = 2'd3
   } drpState_t;

endpackage

// File: rtl/drp_port_capture.sv
// Per-requester capture stage for the DRP arbiter. Latches one request
// (address, write enable, write data) and holds it pending until the arbiter
// reports completion. A den held high across completion is not re-captured.
// Ports:
//   clk, reset          clock, async active-high reset
//   i_den/i_dwe/i_daddr/i_di   requester DRP signals
//   i_complete          arbiter strobes this in the cycle it drives mN_drdy
//   o_pending           a captured request is waiting for / in service
//   o_daddr/o_dwe/o_di  holding register contents
module drp_port_capture
   import sata_phy_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_den,
   input  logic                  i_dwe,
   input  logic [DRP_ADDR_W-1:0] i_daddr,
   input  logic [DRP_DATA_W-1:0] i_di,
   input  logic                  i_complete,
   output logic                  o_pending,
   output logic [DRP_ADDR_W-1:0] o_daddr,
   output logic                  o_dwe,
   output logic [DRP_DATA_W-1:0] o_di
);

   logic                  r_pending;
   logic                  r_done;
   logic [DRP_ADDR_W-1:0] r_daddr;
   logic                  r_dwe;
   logic [DRP_DATA_W-1:0] r_di;

   // Capture a new request only when nothing is pending and the previous
   // completion has been acknowledged by den dropping. On completion, done
   // stays set only while den is still high, so a pulse requester can issue
   // again on the very next cycle while a level requester must drop den first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending <= 1'b0;
         r_done    <= 1'b0;
         r_daddr   <= '0;
         r_dwe     <= 1'b0;
         r_di      <= '0;
      end else if (i_complete) begin
         r_pending <= 1'b0;
         r_done    <= i_den;
      end else begin
         if (!i_den) begin
            r_done <= 1'b0;
         end
         if (i_den && !r_pending && !r_done) begin
            r_pending <= 1'b1;
            r_daddr   <= i_daddr;
            r_dwe     <= i_dwe;
            r_di      <= i_di;
         end
      end
   end

   assign o_pending = r_pending;
   assign o_daddr   = r_daddr;
   assign o_dwe     = r_dwe;
   assign o_di      = r_di;

endmodule

// File: rtl/drp_arbiter.sv
// Two-port arbiter in front of a single GTP DRP interface. Port 0 serves
// speed negotiation, port 1 debug/host register access. One transaction is in
// flight at a time; contention alternates between ports; a transaction that
// sees no drdy within TIMEOUT_CYCLES returns 16'hFFFF and pulses o_timeout_err.
// Ports:
//   clk, reset                     clock, async active-high reset
//   i_mN_daddr/den/dwe/di          requester N inputs
//   o_mN_do/o_mN_drdy              requester N read data and completion strobe
//   o_daddr/o_den/o_dwe/o_di       GTP DRP request side
//   i_do/i_drdy                    GTP DRP response side
//   o_owner                        port of the current/last granted transaction
//   o_timeout_err                  one-cycle strobe on timeout
module drp_arbiter
   import sata_phy_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DRP_ADDR_W-1:0] i_m0_daddr,
   input  logic                  i_m0_den,
   input  logic                  i_m0_dwe,
   input  logic [DRP_DATA_W-1:0] i_m0_di,
   output logic [DRP_DATA_W-1:0] o_m0_do,
   output logic                  o_m0_drdy,
   input  logic [DRP_ADDR_W-1:0] i_m1_daddr,
   input  logic                  i_m1_den,
   input  logic                  i_m1_dwe,
   input  logic [DRP_DATA_W-1:0] i_m1_di,
   output logic [DRP_DATA_W-1:0] o_m1_do,
   output logic                  o_m1_drdy,
   output logic [DRP_ADDR_W-1:0] o_daddr,
   output logic                  o_den,
   output logic                  o_dwe,
   output logic [DRP_DATA_W-1:0] o_di,
   input  logic [DRP_DATA_W-1:0] i_do,
   input  logic                  i_drdy,
   output logic                  o_owner,
   output logic                  o_timeout_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   drpState_t             r_state;
   drpState_t             w_nextState;
   logic                  r_owner;
   logic                  r_lastGrant;
   logic [DRP_ADDR_W-1:0] r_daddr;
   logic                  r_dwe;
   logic [DRP_DATA_W-1:0] r_di;
   logic [CNT_W-1:0]      r_count;
   logic [DRP_DATA_W-1:0] r_m0Do;
   logic [DRP_DATA_W-1:0] r_m1Do;

   logic                  w_pending0;
   logic                  w_pending1;
   logic [DRP_ADDR_W-1:0] w_hAddr0;
   logic [DRP_ADDR_W-1:0] w_hAddr1;
   logic                  w_hDwe0;
   logic                  w_hDwe1;
   logic [DRP_DATA_W-1:0] w_hDi0;
   logic [DRP_DATA_W-1:0] w_hDi1;
   logic                  w_anyPending;
   logic                  w_grant;
   logic                  w_cntMax;
   logic                  w_drdy0;
   logic                  w_drdy1;

   drp_port_capture u_cap0 (
      .clk        (clk),
      .reset      (reset),
      .i_den      (i_m0_den),
      .i_dwe      (i_m0_dwe),
      .i_daddr    (i_m0_daddr),
      .i_di       (i_m0_di),
      .i_complete (w_drdy0),
      .o_pending  (w_pending0),
      .o_daddr    (w_hAddr0),
      .o_dwe      (w_hDwe0),
      .o_di       (w_hDi0)
   );

   drp_port_capture u_cap1 (
      .clk        (clk),
      .reset      (reset),
      .i_den      (i_m1_den),
      .i_dwe      (i_m1_dwe),
      .i_daddr    (i_m1_daddr),
      .i_di       (i_m1_di),
      .i_complete (w_drdy1),
      .o_pending  (w_pending1),
      .o_daddr    (w_hAddr1),
      .o_dwe      (w_hDwe1),
      .o_di       (w_hDi1)
   );

   assign w_anyPending = w_pending0 | w_pending1;
   assign w_cntMax     = (r_count == CNT_MAX);

   // Grant selection: under contention the port that was not served last
   // wins; otherwise whichever single port is pending.
   always_comb begin
      if (w_pending0 && w_pending1) begin
         w_grant = ~r_lastGrant;
      end else begin
         w_grant = w_pending1;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_anyPending) begin
               w_nextState = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_nextState = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_drdy || w_cntMax) begin
               w_nextState = ST_RESPOND;
            end
         end
         ST_RESPOND: begin
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: den only in ISSUE, completion strobe to the owner only in
   // RESPOND, timeout strobe in the last WAIT cycle without drdy.
   always_comb begin
      o_den         = (r_state == ST_ISSUE);
      w_drdy0       = (r_state == ST_RESPOND) && !r_owner;
      w_drdy1       = (r_state == ST_RESPOND) && r_owner;
      o_timeout_err = (r_state == ST_WAIT) && !i_drdy && w_cntMax;
   end

   // Datapath: the GTP request fields are loaded at grant and held until the
   // next grant; read data goes straight into the owner's output register so
   // the other port's o_mN_do keeps its old value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner     <= 1'b0;
         r_lastGrant <= 1'b1;
         r_daddr     <= '0;
         r_dwe       <= 1'b0;
         r_di        <= '0;
         r_count     <= '0;
         r_m0Do      <= '0;
         r_m1Do      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_anyPending) begin
                  r_owner <= w_grant;
                  r_daddr <= w_grant ? w_hAddr1 : w_hAddr0;
                  r_dwe   <= w_grant ? w_hDwe1  : w_hDwe0;
                  r_di    <= w_grant ? w_hDi1   : w_hDi0;
               end
            end
            ST_ISSUE: begin
               r_count <= '0;
            end
            ST_WAIT: begin
               if (i_drdy) begin
                  if (r_owner) r_m1Do <= i_do;
                  else         r_m0Do <= i_do;
               end else if (w_cntMax) begin
                  if (r_owner) r_m1Do <= DRP_TIMEOUT_FILL;
                  else         r_m0Do <= DRP_TIMEOUT_FILL;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            ST_RESPOND: begin
               r_lastGrant <= r_owner;
            end
            default: begin
               r_count <= '0;
            end
         endcase
      end
   end

   assign o_daddr   = r_daddr;
   assign o_dwe     = r_dwe;
   assign o_di      = r_di;
   assign o_owner   = r_owner;
   assign o_m0_do   = r_m0Do;
   assign o_m1_do   = r_m1Do;
   assign o_m0_drdy = w_drdy0;
   assign o_m1_drdy = w_drdy1;

endmodule

// File: tb/tb_drp_arbiter.sv
// Self-checking bench for drp_arbiter. A GTP model answers each den from a
// small register image after a programmable delay; expected issues and
// per-port completions are queued when requests are driven and consumed when
// the DUT issues or completes.
module tb_drp_arbiter;

   localparam int TIMEOUT = 64;

   typedef struct {
      bit          port;
      logic [6:0]  addr;
      bit          we;
      logic [15:0] di;
   } issue_t;

   logic        clk;
   logic        reset;
   logic [6:0]  i_m0_daddr;
   logic        i_m0_den;
   logic        i_m0_dwe;
   logic [15:0] i_m0_di;
   logic [15:0] o_m0_do;
   logic        o_m0_drdy;
   logic [6:0]  i_m1_daddr;
   logic        i_m1_den;
   logic        i_m1_dwe;
   logic [15:0] i_m1_di;
   logic [15:0] o_m1_do;
   logic        o_m1_drdy;
   logic [6:0]  o_daddr;
   logic        o_den;
   logic        o_dwe;
   logic [15:0] o_di;
   logic [15:0] i_do;
   logic        i_drdy;
   logic        o_owner;
   logic        o_timeout_err;

   int          nChecks = 0;
   int          nFails = 0;
   int          issueCount = 0;
   int          drdyCount0 = 0;
   int          drdyCount1 = 0;
   bit          gtpMute = 0;
   bit          skipLat = 0;
   int          gtpDelay = 3;
   bit          modelLastGrant = 1;
   logic [15:0] gtpMem [128];
   issue_t      expIssueQ [$];
   logic [15:0] expQ0 [$];
   logic [15:0] expQ1 [$];
   issue_t      rspIssue;
   logic [6:0]  rspAddr;
   bit          rspPort;

   drp_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_m0_daddr    (i_m0_daddr),
      .i_m0_den      (i_m0_den),
      .i_m0_dwe      (i_m0_dwe),
      .i_m0_di       (i_m0_di),
      .o_m0_do       (o_m0_do),
      .o_m0_drdy     (o_m0_drdy),
      .i_m1_daddr    (i_m1_daddr),
      .i_m1_den      (i_m1_den),
      .i_m1_dwe      (i_m1_dwe),
      .i_m1_di       (i_m1_di),
      .o_m1_do       (o_m1_do),
      .o_m1_drdy     (o_m1_drdy),
      .o_daddr       (o_daddr),
      .o_den         (o_den),
      .o_dwe         (o_dwe),
      .o_di          (o_di),
      .i_do          (i_do),
      .i_drdy        (i_drdy),
      .o_owner       (o_owner),
      .o_timeout_err (o_timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Queue the expected issue and completion for one port
   task automatic expectTxn(input bit port, input logic [6:0] addr, input bit we,
                            input logic [15:0] di);
      issue_t e;
      logic [15:0] rd;
      e.port = port;
      e.addr = addr;
      e.we   = we;
      e.di   = di;
      expIssueQ.push_back(e);
      rd = gtpMute ? 16'hFFFF : gtpMem[addr];
      if (port) expQ1.push_back(rd);
      else      expQ0.push_back(rd);
      modelLastGrant = port;
   endtask

   task automatic waitCompletions(input int t0, input int t1, input string tag);
      int budget;
      budget = 400;
      while ((drdyCount0 < t0 || drdyCount1 < t1) && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      checkOutput(tag, (drdyCount0 >= t0 && drdyCount1 >= t1), 1);
   endtask

   // One-cycle request pulses on the selected ports in the same cycle
   task automatic applyStimulus(input bit use0, input bit use1,
                                input logic [6:0] a0, input bit we0, input logic [15:0] d0,
                                input logic [6:0] a1, input bit we1, input logic [15:0] d1);
      int t0;
      int t1;
      bit first;
      t0 = drdyCount0 + int'(use0);
      t1 = drdyCount1 + int'(use1);
      if (use0 && use1) begin
         first = ~modelLastGrant;
         if (first) begin
            expectTxn(1, a1, we1, d1);
            expectTxn(0, a0, we0, d0);
         end else begin
            expectTxn(0, a0, we0, d0);
            expectTxn(1, a1, we1, d1);
         end
      end else if (use0) begin
         expectTxn(0, a0, we0, d0);
      end else if (use1) begin
         expectTxn(1, a1, we1, d1);
      end
      @(posedge clk);
      #1;
      i_m0_den = use0; i_m0_daddr = a0; i_m0_dwe = we0; i_m0_di = d0;
      i_m1_den = use1; i_m1_daddr = a1; i_m1_dwe = we1; i_m1_di = d1;
      @(posedge clk);
      #1;
      i_m0_den = 1'b0;
      i_m1_den = 1'b0;
      waitCompletions(t0, t1, "completions");
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      modelLastGrant = 1;
   endtask

   // GTP model: check each den against the expected issue order, then answer
   // with the register image after gtpDelay cycles unless muted.
   initial begin
      i_drdy = 1'b0;
      i_do   = '0;
      forever begin
         @(posedge clk);
         #1;
         if (o_den) begin
            issueCount++;
            rspAddr = o_daddr;
            rspPort = o_owner;
            checkOutput("issueQueued", (expIssueQ.size() > 0), 1);
            if (expIssueQ.size() > 0) begin
               rspIssue = expIssueQ.pop_front();
               checkOutput("issuePort", o_owner, rspIssue.port);
               checkOutput("issueAddr", o_daddr, rspIssue.addr);
               checkOutput("issueWe", o_dwe, rspIssue.we);
               checkOutput("issueDi", o_di, rspIssue.di);
               rspPort = rspIssue.port;
            end
            @(posedge clk);
            #1;
            checkOutput("denPulse", o_den, 0);
            if (!gtpMute) begin
               repeat (gtpDelay - 1) @(posedge clk);
               #1;
               i_do   = gtpMem[rspAddr];
               i_drdy = 1'b1;
               @(posedge clk);
               #1;
               i_drdy = 1'b0;
               i_do   = 16'hDEAD;
               if (!skipLat) begin
                  checkOutput("drdyLat", rspPort ? o_m1_drdy : o_m0_drdy, 1);
               end
            end
         end
      end
   end

   // Completion monitor: every mN_drdy must match a queued expectation
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (o_m0_drdy || o_m1_drdy) begin
            checkOutput("singleDrdy", (o_m0_drdy & o_m1_drdy), 0);
         end
         if (o_m0_drdy) begin
            drdyCount0++;
            checkOutput("m0Queued", (expQ0.size() > 0), 1);
            if (expQ0.size() > 0) checkOutput("m0_do", o_m0_do, expQ0.pop_front());
         end
         if (o_m1_drdy) begin
            drdyCount1++;
            checkOutput("m1Queued", (expQ1.size() > 0), 1);
            if (expQ1.size() > 0) checkOutput("m1_do", o_m1_do, expQ1.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base0;
      int base1;
      int issueBase;
      int budget;

      for (int i = 0; i < 128; i++) gtpMem[i] = 16'hC000 + 16'(i * 3);
      gtpMem[7'h46] = 16'h1234;

      reset = 1'b1;
      i_m0_den = 0; i_m0_daddr = '0; i_m0_dwe = 0; i_m0_di = '0;
      i_m1_den = 0; i_m1_daddr = '0; i_m1_dwe = 0; i_m1_di = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstDen", o_den, 0);
      checkOutput("rstDaddr", o_daddr, 0);
      checkOutput("rstDi", o_di, 0);
      checkOutput("rstOwner", o_owner, 0);
      checkOutput("rstM0Do", o_m0_do, 0);
      checkOutput("rstTimeout", o_timeout_err, 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Port 0 level read of 0x46, GTP answers after 3 cycles
      $display("[TB] held-den read");
      issueBase = issueCount;
      base0 = drdyCount0;
      expectTxn(0, 7'h46, 0, 16'h0000);
      i_m0_den = 1'b1; i_m0_daddr = 7'h46; i_m0_dwe = 1'b0; i_m0_di = 16'h0000;
      @(posedge clk);
      #1;
      checkOutput("latT1", o_den, 0);
      @(posedge clk);
      #1;
      checkOutput("latT2", o_den, 1);
      waitCompletions(base0 + 1, drdyCount1, "heldDone");
      repeat (6) @(posedge clk);
      #1;
      i_m0_den = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("heldOneIssue", issueCount - issueBase, 1);
      checkOutput("heldOneDrdy", drdyCount0 - base0, 1);

      // Same-cycle contention straight after reset: port 0 wins
      $display("[TB] contention after reset");
      applyReset();
      base0 = drdyCount0;
      base1 = drdyCount1;
      applyStimulus(1, 1, 7'h45, 1, 16'h8000, 7'h0A, 0, 16'h0000);
      checkOutput("cont0Count", drdyCount0 - base0, 1);
      checkOutput("cont1Count", drdyCount1 - base1, 1);

      // Ten contention rounds; odd rounds are preceded by a lone port 0
      // request so port 1 should win that contention
      $display("[TB] alternation rounds");
      for (int r = 0; r < 10; r++) begin
         if (r % 2 == 1) begin
            applyStimulus(1, 0, 7'h50 + 7'(r), 0, 16'h0000, 7'h00, 0, 16'h0000);
         end
         applyStimulus(1, 1, 7'h20 + 7'(r), r[0], 16'($urandom),
                       7'h30 + 7'(r), ~r[0], 16'($urandom));
      end

      // Timeout: GTP stays silent
      $display("[TB] timeout");
      gtpMute = 1;
      expectTxn(0, 7'h10, 0, 16'h0000);
      @(posedge clk);
      #1;
      i_m0_den = 1'b1; i_m0_daddr = 7'h10; i_m0_dwe = 1'b0; i_m0_di = 16'h0000;
      @(posedge clk);
      #1;
      i_m0_den = 1'b0;
      budget = 10;
      while (!o_den && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      checkOutput("toDenSeen", o_den, 1);
      repeat (TIMEOUT - 1) @(posedge clk);
      #1;
      checkOutput("toEarly", o_timeout_err, 0);
      @(posedge clk);
      #1;
      checkOutput("toStrobe", o_timeout_err, 1);
      @(posedge clk);
      #1;
      checkOutput("toStrobeEnd", o_timeout_err, 0);
      checkOutput("toDrdy", o_m0_drdy, 1);
      gtpMute = 0;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(1, 0, 7'h11, 0, 16'h0000, 7'h00, 0, 16'h0000);

      // Reset while waiting for the GTP; the late drdy must be ignored
      $display("[TB] reset in WAIT");
      gtpDelay = 20;
      skipLat = 1;
      begin
         issue_t e;
         e.port = 1; e.addr = 7'h0A; e.we = 0; e.di = 16'h0000;
         expIssueQ.push_back(e);
      end
      issueBase = issueCount;
      base0 = drdyCount0;
      base1 = drdyCount1;
      @(posedge clk);
      #1;
      i_m1_den = 1'b1; i_m1_daddr = 7'h0A; i_m1_dwe = 1'b0; i_m1_di = 16'h0000;
      @(posedge clk);
      #1;
      i_m1_den = 1'b0;
      budget = 10;
      while (issueCount == issueBase && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      checkOutput("abortIssued", issueCount - issueBase, 1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #2;
      checkOutput("abortDen", o_den, 0);
      checkOutput("abortDaddr", o_daddr, 0);
      checkOutput("abortDwe", o_dwe, 0);
      checkOutput("abortDi", o_di, 0);
      checkOutput("abortOwner", o_owner, 0);
      checkOutput("abortM0Do", o_m0_do, 0);
      checkOutput("abortM1Do", o_m1_do, 0);
      checkOutput("abortDrdy", {o_m0_drdy, o_m1_drdy}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      modelLastGrant = 1;
      repeat (30) @(posedge clk);
      #1;
      checkOutput("abortNoDrdy1", drdyCount1 - base1, 0);
      checkOutput("abortNoDrdy0", drdyCount0 - base0, 0);
      checkOutput("abortNoReissue", issueCount - issueBase, 1);
      gtpDelay = 3;
      skipLat = 0;

      // Recovery: contention after the abort goes to port 0 first
      applyStimulus(1, 1, 7'h46, 0, 16'h0000, 7'h47, 1, 16'h5A5A);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("issueQEmpty", expIssueQ.size(), 0);
      checkOutput("expQ0Empty", expQ0.size(), 0);
      checkOutput("expQ1Empty", expQ1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
